mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported 32x32 data memory.
- Requester 0 is the CPU load/store path. Requester 1 is the loader/debug/DMA path.
- Accepts one request at a time using a valid/ready handshake and picks round-robin on ties.
- Drives the memory's level-sensitive write/read port for exactly one cycle per access, then returns a registered response to the winner.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width on requester and memory ports.
- DEPTH, 32, number of memory words; used only by the optional range check.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- REQ0_VALID  in  1  requester 0 has a request pending.
- REQ0_WRITE  in  1  1=write, 0=read.
- REQ0_ADDR  in  ADDR_W  word address.
- REQ0_WDATA  in  DATA_W  write data.
- REQ0_READY  out  1  request accepted this cycle.
- RSP0_VALID  out  1  one-cycle response strobe.
- RSP0_RDATA  out  DATA_W  read data; 0 for writes.
- RSP0_ERR  out  1  address error.
- REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA, REQ1_READY, RSP1_VALID, RSP1_RDATA, RSP1_ERR: same as requester 0, for requester 1.
- MEM_WRITE  out  1  to memory write enable.
- MEM_ADRESS  out  ADDR_W  to memory address.
- MEM_WDATA  out  DATA_W  to memory write data.
- MEM_RDATA  in  DATA_W  from memory read data (combinational).

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low on RST_N.
- Reset values:
  - State = IDLE.
  - LAST (last-served id) = 1, so requester 0 wins the first tie.
  - All outputs = 0, including MEM_WRITE = 0, MEM_ADRESS = 0 and MEM_WDATA = 0.
  - Latched request registers = 0.
- Reset mid-operation: any in-flight request is abandoned and no response is issued. MEM_WRITE is 0 from the first cycle reset is sampled.
- State machine has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant choice: if exactly one REQx_VALID is high, grant it. If both are high, grant the id != LAST. If none, stay in IDLE.
  - REQx_READY is combinational: high in IDLE only for the granted id.
  - A handshake occurs when VALID && READY. On it, latch WRITE, ADDR, WDATA and id, then go to ACCESS.
- ACCESS (exactly one cycle):
  - MEM_ADRESS and MEM_WDATA show the latched values.
  - MEM_WRITE equals the latched WRITE.
  - On the clock edge, capture MEM_RDATA into the response register (capture 0 if the access was a write), then go to RESP.
- RESP (exactly one cycle):
  - RSPid_VALID = 1 with RSPid_RDATA held.
  - LAST <= id, then go to IDLE.
  - RSP*_RDATA holds its value until the next response to that id.
- MEM_WRITE must be 0 in every state except ACCESS, because the memory writes whenever the enable is high. MEM_ADRESS and MEM_WDATA keep their latched values outside ACCESS.
- Latency and throughput:
  - Handshake in cycle N, memory access in N+1, RSP_VALID in N+2.
  - Peak throughput is one request per 3 cycles; the next handshake is possible in cycle N+3.
- Protocol rules:
  - A requester holds VALID and its payload stable until READY. Deasserting VALID before READY is legal, and the request is dropped.
  - READY is never high for both ids in the same cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Width rules: no arithmetic; addresses pass through unmodified.

Optional Feature:
- Macro: MEM_ARB_ADDR_CHECK_EN.
- Defined: in ACCESS, if the latched ADDR >= DEPTH, MEM_WRITE is forced to 0. The response then has RSP_ERR = 1 and RSP_RDATA = 0. Timing is unchanged.
- Undefined: no check is made, RSP*_ERR is tied to 0, and every address goes to memory as-is.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the requester id typedef (1 bit);
  - DATA_W/ADDR_W default constants;
  - a request struct {write, addr, wdata}.
- One sub-module, rr_pick2: a 2-way round-robin picker.
  - Inputs: valid[1:0] and last.
  - Outputs: grant_valid and grant_id.
  - Purely combinational.

Test Plan:
- Reset, then REQ0 write addr 5 data 32'hDEADBEEF, then REQ0 read addr 5. The write gives RSP0_VALID at N+2 with RDATA 0; the read gives RSP0_RDATA = 32'hDEADBEEF at N+2. MEM_WRITE is high exactly 1 cycle in total.
- Both valid continuously for 8 requests after reset: grants go 0,1,0,1,0,1,0,1, and REQ0_READY/REQ1_READY are never high together.
- REQ1 write addr 3 data 7 concurrently with REQ0 read addr 3 (REQ1 wins because LAST=0 after a prior REQ0 access): RSP0_RDATA = 7.
- RST_N low during ACCESS of a write to addr 9: no RSP issued, and MEM_WRITE is 0 the next cycle. After reset, a read of addr 9 returns the prior contents.
- With MEM_ARB_ADDR_CHECK_EN defined, a write to addr 40 (DEPTH=32) gives RSP_ERR = 1, RDATA = 0, and MEM_WRITE stays 0 throughout. Without the macro, RSP_ERR = 0.
- REQ0 drops VALID before READY while REQ1 holds the grant: no RSP0 is issued, and the FSM returns to IDLE normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter (mem_arbiter)
// and its round-robin picker (rr_pick2).
// Ports: none (package).
// Related build macro: MEM_ARB_ADDR_CHECK_EN (consumed by mem_arbiter).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Requester id: 0 = CPU load/store path, 1 = loader/debug/DMA path.
  typedef logic req_id_t;

  // Latched request payload. Field widths follow the package defaults, so a
  // top-level width override must be matched by a change here.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Purely combinational 2-way round-robin picker.
// Ports:
//   valid[1:0]  in   request pending per id
//   last        in   id served most recently
//   grant_valid out  at least one request pending
//   grant_id    out  chosen id; on a tie the id that was not served last
// -----------------------------------------------------------------------------
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = other_id(last);
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter/sequencer in front of a single-ported data memory. One
// request is accepted at a time (valid/ready), the memory port is driven for
// exactly one cycle, and a registered response strobe goes back to the winner.
// Handshake in cycle N, memory access in N+1, response in N+2.
//
// Optional build macro: MEM_ARB_ADDR_CHECK_EN
//   defined   - latched addresses >= DEPTH suppress the memory write and
//               answer with RSP_ERR=1, RSP_RDATA=0 (same timing).
//   undefined - no range check, RSP*_ERR is always 0.
//
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   REQx_VALID/WRITE/ADDR/WDATA requester x request payload (x = 0, 1)
//   REQx_READY                 request accepted this cycle (combinational)
//   RSPx_VALID                 one-cycle response strobe
//   RSPx_RDATA, RSPx_ERR       response data (0 for writes) and address error
//   MEM_WRITE/ADRESS/WDATA     memory write enable, address, write data
//   MEM_RDATA                  memory read data (combinational from memory)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              REQ0_VALID,
  input  logic              REQ0_WRITE,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  output logic              REQ0_READY,
  output logic              RSP0_VALID,
  output logic [DATA_W-1:0] RSP0_RDATA,
  output logic              RSP0_ERR,

  input  logic              REQ1_VALID,
  input  logic              REQ1_WRITE,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  output logic              REQ1_READY,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP1_RDATA,
  output logic              RSP1_ERR,

  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADRESS,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  arb_state_e        state_q, state_d;
  req_id_t           last_q, last_d;
  req_id_t           id_q, id_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;

  logic              grant_valid;
  req_id_t           grant_id;
  logic              addr_err;
  logic [DATA_W-1:0] capture_data;

  rr_pick2 u_pick (
    .valid       ({REQ1_VALID, REQ0_VALID}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign addr_err = (req_q.addr >= ADDR_W'(DEPTH));
`else
  assign addr_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. READY is only offered to a requester whose VALID is high,
  // so a grant in IDLE is always a handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if (state_q == ST_IDLE && grant_valid) begin
      REQ0_READY = (grant_id == 1'b0);
      REQ1_READY = (grant_id == 1'b1);
    end

    // The memory writes whenever the enable is high, so it is qualified by
    // RST_N as well: an access abandoned by reset never lands in memory.
    MEM_WRITE  = (state_q == ST_ACCESS) && req_q.write && !addr_err && RST_N;
    MEM_ADRESS = req_q.addr;
    MEM_WDATA  = req_q.wdata;

    RSP0_VALID = (state_q == ST_RESP) && (id_q == 1'b0);
    RSP1_VALID = (state_q == ST_RESP) && (id_q == 1'b1);
    RSP0_RDATA = rdata0_q;
    RSP1_RDATA = rdata1_q;
    RSP0_ERR   = err0_q;
    RSP1_ERR   = err1_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: latch on handshake, capture read data at the end of
  // ACCESS, update the round-robin pointer as the response goes out.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_d        = req_q;
    id_d         = id_q;
    last_d       = last_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    capture_data = '0;

    if (state_q == ST_IDLE && grant_valid) begin
      id_d = grant_id;
      if (grant_id == 1'b0) begin
        req_d.write = REQ0_WRITE;
        req_d.addr  = REQ0_ADDR;
        req_d.wdata = REQ0_WDATA;
      end else begin
        req_d.write = REQ1_WRITE;
        req_d.addr  = REQ1_ADDR;
        req_d.wdata = REQ1_WDATA;
      end
    end

    if (state_q == ST_ACCESS) begin
      // Writes and out-of-range accesses return zero data.
      capture_data = (req_q.write || addr_err) ? '0 : MEM_RDATA;
      if (id_q == 1'b0) begin
        rdata0_d = capture_data;
        err0_d   = addr_err;
      end else begin
        rdata1_d = capture_data;
        err1_d   = addr_err;
      end
    end

    if (state_q == ST_RESP) begin
      last_d = id_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      req_q    <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first tie
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      req_q    <= req_d;
      id_q     <= id_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Each requester is fed from a queue and
// holds VALID while its queue is non-empty. The reference model predicts the
// grant order (strict alternation while both queues are non-empty, starting
// with the id that was not served last) and the response contents from its own
// word-array copy of the memory. A separate behavioural memory answers the
// DUT's memory port. Honours MEM_ARB_ADDR_CHECK_EN like the design.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DEPTH = 32;
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0_VALID, REQ0_WRITE, REQ0_READY, RSP0_VALID, RSP0_ERR;
  logic [31:0] REQ0_ADDR, REQ0_WDATA, RSP0_RDATA;
  logic        REQ1_VALID, REQ1_WRITE, REQ1_READY, RSP1_VALID, RSP1_ERR;
  logic [31:0] REQ1_ADDR, REQ1_WDATA, RSP1_RDATA;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADRESS, MEM_WDATA, MEM_RDATA;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY), .RSP0_VALID(RSP0_VALID),
    .RSP0_RDATA(RSP0_RDATA), .RSP0_ERR(RSP0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY), .RSP1_VALID(RSP1_VALID),
    .RSP1_RDATA(RSP1_RDATA), .RSP1_ERR(RSP1_ERR),
    .MEM_WRITE(MEM_WRITE), .MEM_ADRESS(MEM_ADRESS), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  // Behavioural memory on the DUT side (64 words so out-of-range addresses
  // used by the bench still have somewhere to land when unchecked).
  logic [31:0] tb_mem [0:63];
  logic        mem_clear;
  int          mem_wr_cnt;
  assign MEM_RDATA = tb_mem[MEM_ADRESS[5:0]];

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h5A00_0000 | 32'(i);
      mem_wr_cnt <= 0;
    end else if (MEM_WRITE) begin
      tb_mem[MEM_ADRESS[5:0]] <= MEM_WDATA;
      mem_wr_cnt <= mem_wr_cnt + 1;
    end
  end

  // Reference model state
  logic [31:0] mem_m [0:63];
  bit          last_m;

  // Stimulus queues, expectations and observation logs
  req_t        q0[$], q1[$];
  int          exp_id[$];
  logic [31:0] exp_data[$];
  logic        exp_err[$];
  int          exp_writes;
  int          hs_id[$], hs_cyc[$], rs_id[$], rs_cyc[$];
  logic [31:0] rs_data[$];
  logic        rs_err[$];
  int          both_rdy;
  int          checks = 0;
  int          errors = 0;

  // Predict grant order and responses for the queued requests.
  task automatic build_expected();
    req_t c0[$], c1[$];
    req_t r;
    int   id;
    bit   in_range;
    c0 = q0;
    c1 = q1;
    exp_id.delete(); exp_data.delete(); exp_err.delete();
    exp_writes = 0;
    while (c0.size() + c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) id = last_m ? 0 : 1;
      else id = (c0.size() > 0) ? 0 : 1;
      r = (id == 0) ? c0.pop_front() : c1.pop_front();
      in_range = !CHECK_EN || (r.addr < DEPTH);
      exp_id.push_back(id);
      exp_err.push_back(!in_range);
      if (!in_range) begin
        exp_data.push_back(32'h0);
      end else if (r.wr) begin
        mem_m[r.addr[5:0]] = r.wdata;
        exp_data.push_back(32'h0);
        exp_writes++;
      end else begin
        exp_data.push_back(mem_m[r.addr[5:0]]);
      end
      last_m = (id == 1);
    end
  endtask

  // Drive both queues until empty, logging handshakes and responses with the
  // cycle they were seen in. Starts and ends 1 time unit after a rising edge.
  task automatic run_engine(input int max_cycles);
    int tail;
    tail = 0;
    hs_id.delete(); hs_cyc.delete(); rs_id.delete(); rs_cyc.delete();
    rs_data.delete(); rs_err.delete();
    both_rdy = 0;
    for (int c = 0; c < max_cycles && tail < 5; c++) begin
      REQ0_VALID = (q0.size() > 0);
      if (q0.size() > 0) begin
        REQ0_WRITE = q0[0].wr; REQ0_ADDR = q0[0].addr; REQ0_WDATA = q0[0].wdata;
      end
      REQ1_VALID = (q1.size() > 0);
      if (q1.size() > 0) begin
        REQ1_WRITE = q1[0].wr; REQ1_ADDR = q1[0].addr; REQ1_WDATA = q1[0].wdata;
      end
      #1;
      if (REQ0_READY && REQ1_READY) both_rdy++;
      if (RSP0_VALID) begin
        rs_id.push_back(0); rs_cyc.push_back(c); rs_data.push_back(RSP0_RDATA); rs_err.push_back(RSP0_ERR);
      end
      if (RSP1_VALID) begin
        rs_id.push_back(1); rs_cyc.push_back(c); rs_data.push_back(RSP1_RDATA); rs_err.push_back(RSP1_ERR);
      end
      if (REQ0_VALID && REQ0_READY) begin
        hs_id.push_back(0); hs_cyc.push_back(c); void'(q0.pop_front());
      end
      if (REQ1_VALID && REQ1_READY) begin
        hs_id.push_back(1); hs_cyc.push_back(c); void'(q1.pop_front());
      end
      if (q0.size() == 0 && q1.size() == 0) tail++;
      @(posedge CLK); #1;
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    mem_clear = 1'b0;
    last_m = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR, MEM_WRITE} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR, MEM_WRITE});
    end
    checks++;
    if ({MEM_ADRESS, MEM_WDATA, RSP0_RDATA, RSP1_RDATA} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: adr=%h wd=%h r0=%h r1=%h expected all 0", MEM_ADRESS, MEM_WDATA, RSP0_RDATA, RSP1_RDATA);
    end
    // First tie after reset goes to requester 0; withdraw before the edge.
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: got ready0/1=%b expected 10", {REQ0_READY, REQ1_READY});
    end
    #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read();
    req_t r;
    int   wc;
    r.wr = 1; r.addr = 5; r.wdata = 32'hDEADBEEF; q0.push_back(r);
    r.wr = 0; r.wdata = 0; q0.push_back(r);
    build_expected();
    wc = mem_wr_cnt;
    run_engine(40);
    checks++;
    if (rs_id.size() != 2 || hs_id.size() != 2) begin
      errors++;
      $display("FAIL wr_rd_count: got rsp=%0d hs=%0d expected 2 2", rs_id.size(), hs_id.size());
    end else begin
      checks++;
      if (rs_data[0] !== 32'h0 || rs_data[1] !== 32'hDEADBEEF || rs_id[0] != 0 || rs_id[1] != 0) begin
        errors++;
        $display("FAIL wr_rd_data: got %h/%h ids %0d%0d expected 00000000/deadbeef ids 00", rs_data[0], rs_data[1], rs_id[0], rs_id[1]);
      end
      checks++;
      if (rs_cyc[0] - hs_cyc[0] != 2 || rs_cyc[1] - hs_cyc[1] != 2) begin
        errors++;
        $display("FAIL wr_rd_latency: got %0d/%0d expected 2/2", rs_cyc[0] - hs_cyc[0], rs_cyc[1] - hs_cyc[1]);
      end
    end
    checks++;
    if (mem_wr_cnt - wc != 1) begin
      errors++;
      $display("FAIL wr_rd_mem_write_cycles: got %0d expected 1", mem_wr_cnt - wc);
    end
  endtask

  task automatic test_fairness();
    req_t r;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      r.wr = 0; r.wdata = 0;
      r.addr = $urandom_range(0, 31); q0.push_back(r);
      r.addr = $urandom_range(0, 31); q1.push_back(r);
    end
    build_expected();
    run_engine(60);
    checks++;
    if (hs_id.size() != 8 || rs_id.size() != 8) begin
      errors++;
      $display("FAIL fair_count: got hs=%0d rsp=%0d expected 8 8", hs_id.size(), rs_id.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= hs_id.size() || hs_id[k] != k % 2) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, (k < hs_id.size()) ? hs_id[k] : -1, k % 2);
      end
      if (k < rs_id.size()) begin
        checks++;
        if (rs_id[k] != exp_id[k] || rs_data[k] !== exp_data[k]) begin
          errors++;
          $display("FAIL fair_rsp[%0d]: got id%0d %h expected id%0d %h", k, rs_id[k], rs_data[k], exp_id[k], exp_data[k]);
        end
      end
      if (k > 0 && k < hs_cyc.size()) begin
        checks++;
        if (hs_cyc[k] - hs_cyc[k-1] != 3) begin
          errors++;
          $display("FAIL fair_spacing[%0d]: got %0d expected 3", k, hs_cyc[k] - hs_cyc[k-1]);
        end
      end
    end
    checks++;
    if (both_rdy != 0) begin
      errors++;
      $display("FAIL fair_both_ready: got %0d cycles expected 0", both_rdy);
    end
  endtask

  task automatic test_concurrent();
    req_t r;
    bit   found;
    r.wr = 0; r.addr = 1; r.wdata = 0; q0.push_back(r);
    build_expected();
    run_engine(30);
    r.wr = 0; r.addr = 3; r.wdata = 0; q0.push_back(r);
    r.wr = 1; r.addr = 3; r.wdata = 32'd7; q1.push_back(r);
    build_expected();
    run_engine(40);
    checks++;
    if (hs_id.size() != 2 || hs_id[0] != 1) begin
      errors++;
      $display("FAIL conc_first_grant: got %0d expected 1", (hs_id.size() > 0) ? hs_id[0] : -1);
    end
    found = 0;
    for (int k = 0; k < rs_id.size(); k++) begin
      if (rs_id[k] == 0) begin
        found = 1;
        checks++;
        if (rs_data[k] !== 32'd7) begin
          errors++;
          $display("FAIL conc_rdata0: got %h expected 00000007", rs_data[k]);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL conc_rsp0_missing: got none expected 1");
    end
  endtask

  task automatic test_reset_mid();
    req_t r;
    int   wc, seen;
    r.wr = 1; r.addr = 9; r.wdata = 32'h1111_2222; q0.push_back(r);
    build_expected();
    run_engine(30);
    wc = mem_wr_cnt;
    REQ0_WRITE = 1'b1; REQ0_ADDR = 9; REQ0_WDATA = 32'h3333_4444; REQ0_VALID = 1'b1;
    #1;
    checks++;
    if (REQ0_READY !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b expected 1", REQ0_READY);
    end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    checks++;
    if (MEM_WRITE !== 1'b1 || MEM_ADRESS !== 32'd9) begin
      errors++;
      $display("FAIL rstmid_access: got we=%b adr=%h expected 1 00000009", MEM_WRITE, MEM_ADRESS);
    end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (MEM_WRITE !== 1'b0 || RSP0_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got we=%b rsp0=%b expected 0 0", MEM_WRITE, RSP0_VALID);
    end
    RST_N = 1'b1;
    last_m = 1'b1;
    seen = 0;
    repeat (5) begin
      if (RSP0_VALID || RSP1_VALID) seen++;
      @(posedge CLK); #1;
    end
    checks++;
    if (seen != 0 || mem_wr_cnt != wc) begin
      errors++;
      $display("FAIL rstmid_abandon: got rsp=%0d writes=%0d expected 0 0", seen, mem_wr_cnt - wc);
    end
    r.wr = 0; r.addr = 9; r.wdata = 0; q0.push_back(r);
    build_expected();
    run_engine(30);
    checks++;
    if (rs_data.size() != 1 || rs_data[0] !== 32'h1111_2222) begin
      errors++;
      $display("FAIL rstmid_readback: got %h expected 11112222", (rs_data.size() > 0) ? rs_data[0] : 32'hx);
    end
  endtask

  task automatic test_addr_check();
    req_t        r;
    int          wc;
    logic [31:0] exp_rd;
    r.wr = 1; r.addr = 40; r.wdata = 32'hCAFE_F00D; q0.push_back(r);
    r.wr = 0; r.wdata = 0; q0.push_back(r);
    build_expected();
    exp_rd = CHECK_EN ? 32'h0 : 32'hCAFE_F00D;
    wc = mem_wr_cnt;
    run_engine(40);
    checks++;
    if (rs_id.size() != 2) begin
      errors++;
      $display("FAIL addrchk_count: got %0d expected 2", rs_id.size());
    end else begin
      checks++;
      if (rs_err[0] !== CHECK_EN || rs_err[1] !== CHECK_EN || rs_data[0] !== 32'h0 || rs_data[1] !== exp_rd) begin
        errors++;
        $display("FAIL addrchk_rsp: got err %b%b data %h/%h expected err %b%b data 00000000/%h",
                 rs_err[0], rs_err[1], rs_data[0], rs_data[1], CHECK_EN, CHECK_EN, exp_rd);
      end
    end
    checks++;
    if (mem_wr_cnt - wc != (CHECK_EN ? 0 : 1)) begin
      errors++;
      $display("FAIL addrchk_mem_write: got %0d expected %0d", mem_wr_cnt - wc, CHECK_EN ? 0 : 1);
    end
  endtask

  task automatic test_drop();
    req_t r;
    int   seen;
    REQ1_WRITE = 1'b0; REQ1_ADDR = 2; REQ1_WDATA = 0; REQ1_VALID = 1'b1;
    #1;
    checks++;
    if (REQ1_READY !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready1: got %b expected 1", REQ1_READY);
    end
    @(posedge CLK); #1;
    REQ1_VALID = 1'b0;
    REQ0_WRITE = 1'b0; REQ0_ADDR = 4; REQ0_WDATA = 0; REQ0_VALID = 1'b1;
    #1;
    seen = REQ0_READY;
    @(posedge CLK); #2;
    checks++;
    if (RSP1_VALID !== 1'b1 || RSP1_RDATA !== mem_m[2] || (seen | REQ0_READY) != 0) begin
      errors++;
      $display("FAIL drop_rsp1: got v=%b d=%h rdy0=%0d expected 1 %h 0", RSP1_VALID, RSP1_RDATA, seen | REQ0_READY, mem_m[2]);
    end
    REQ0_VALID = 1'b0;
    last_m = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (RSP0_VALID) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_no_rsp0: got %0d expected 0", seen);
    end
    r.wr = 0; r.addr = 4; r.wdata = 0; q0.push_back(r);
    build_expected();
    run_engine(30);
    checks++;
    if (rs_id.size() != 1 || rs_data[0] !== mem_m[4]) begin
      errors++;
      $display("FAIL drop_recover: got %0d rsp expected 1 with %h", rs_id.size(), mem_m[4]);
    end
  endtask

  task automatic test_random();
    req_t r;
    int   n0, n1, wc;
    for (int round = 0; round < 4; round++) begin
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(1, 5);
      for (int k = 0; k < n0 + n1; k++) begin
        r.wr = $urandom_range(0, 1);
        r.addr = $urandom_range(0, 47);
        r.wdata = $urandom;
        if (k < n0) q0.push_back(r); else q1.push_back(r);
      end
      build_expected();
      wc = mem_wr_cnt;
      run_engine(100);
      checks++;
      if (rs_id.size() != exp_id.size() || hs_id.size() != exp_id.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got hs=%0d rsp=%0d expected %0d", round, hs_id.size(), rs_id.size(), exp_id.size());
      end
      for (int k = 0; k < exp_id.size(); k++) begin
        if (k < rs_id.size() && k < hs_id.size()) begin
          checks++;
          if (hs_id[k] != exp_id[k] || rs_id[k] != exp_id[k] || rs_data[k] !== exp_data[k] ||
              rs_err[k] !== exp_err[k] || rs_cyc[k] - hs_cyc[k] != 2) begin
            errors++;
            $display("FAIL rand%0d_txn[%0d]: got id%0d/%0d %h err%b lat%0d expected id%0d %h err%b lat2",
                     round, k, hs_id[k], rs_id[k], rs_data[k], rs_err[k], rs_cyc[k] - hs_cyc[k],
                     exp_id[k], exp_data[k], exp_err[k]);
          end
        end
      end
      checks++;
      if (mem_wr_cnt - wc != exp_writes || both_rdy != 0) begin
        errors++;
        $display("FAIL rand%0d_mem: got writes=%0d both_ready=%0d expected %0d 0", round, mem_wr_cnt - wc, both_rdy, exp_writes);
      end
    end
  endtask

  initial begin
    mem_clear = 1'b1;
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h5A00_0000 | 32'(i);
    REQ0_WRITE = 0; REQ0_ADDR = 0; REQ0_WDATA = 0;
    REQ1_WRITE = 0; REQ1_ADDR = 0; REQ1_WDATA = 0;
    test_reset();
    test_write_read();
    test_fairness();
    test_concurrent();
    test_reset_mid();
    test_addr_check();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
